// File: rtl/cu_pkg.sv
// Opcodes, datapath select encodings and FSM state encoding for control_unit.
package cu_pkg;

  // Opcodes
  localparam logic [7:0] LDA_IMM = 8'h86;
  localparam logic [7:0] LDA_DIR = 8'h87;
  localparam logic [7:0] LDB_IMM = 8'h88;
  localparam logic [7:0] LDB_DIR = 8'h89;
  localparam logic [7:0] STA_DIR = 8'h96;
  localparam logic [7:0] STB_DIR = 8'h97;
  localparam logic [7:0] ADD_AB  = 8'h42;
  localparam logic [7:0] SUB_AB  = 8'h43;
  localparam logic [7:0] AND_AB  = 8'h44;
  localparam logic [7:0] OR_AB   = 8'h45;
  localparam logic [7:0] INCA    = 8'h46;
  localparam logic [7:0] INCB    = 8'h47;
  localparam logic [7:0] DECA    = 8'h48;
  localparam logic [7:0] DECB    = 8'h49;
  localparam logic [7:0] BRA     = 8'h20;
  localparam logic [7:0] BMI     = 8'h21;
  localparam logic [7:0] BPL     = 8'h22;
  localparam logic [7:0] BEQ     = 8'h23;
  localparam logic [7:0] BNE     = 8'h24;
  localparam logic [7:0] BVS     = 8'h25;
  localparam logic [7:0] BVC     = 8'h26;
  localparam logic [7:0] BCS     = 8'h27;
  localparam logic [7:0] BCC     = 8'h28;

  // ALU operation select
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_INC = 3'b100;
  localparam logic [2:0] ALU_DEC = 3'b101;

  // Bus1 source select
  localparam logic [1:0] BUS1_PC = 2'b00;
  localparam logic [1:0] BUS1_A  = 2'b01;
  localparam logic [1:0] BUS1_B  = 2'b10;

  // Bus2 source select
  localparam logic [1:0] BUS2_ALU  = 2'b00;
  localparam logic [1:0] BUS2_BUS1 = 2'b01;
  localparam logic [1:0] BUS2_MEM  = 2'b10;

  // Bit positions within CCR_Result = {N,Z,V,C}
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [5:0] {
    FETCH_0, FETCH_1, FETCH_2, DECODE_3,
    LDA_IMM_4, LDA_IMM_5, LDA_IMM_6,
    LDA_DIR_4, LDA_DIR_5, LDA_DIR_6, LDA_DIR_7, LDA_DIR_8,
    LDB_IMM_4, LDB_IMM_5, LDB_IMM_6,
    LDB_DIR_4, LDB_DIR_5, LDB_DIR_6, LDB_DIR_7, LDB_DIR_8,
    STA_DIR_4, STA_DIR_5, STA_DIR_6, STA_DIR_7,
    STB_DIR_4, STB_DIR_5, STB_DIR_6, STB_DIR_7,
    ADD_AB_4, SUB_AB_4, AND_AB_4, OR_AB_4,
    INCA_4, INCB_4, DECA_4, DECB_4,
    BR_4, BR_5, BR_6, BR_SKIP
  } state_t;

  // Conditional/unconditional branch opcodes occupy one contiguous range.
  function automatic logic is_branch(input logic [7:0] op);
    return (op >= BRA) && (op <= BCC);
  endfunction

endpackage

// File: rtl/cu_branch_cond.sv
// Branch condition evaluation: low opcode nibble selects a test on {N,Z,V,C}.
module cu_branch_cond
  import cu_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] ccr_i,
  output logic       taken_o
);

  // Select the flag test for the branch encoded in cond_i.
  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      4'h0:    taken_o = 1'b1;
      4'h1:    taken_o =  ccr_i[FLAG_N];
      4'h2:    taken_o = ~ccr_i[FLAG_N];
      4'h3:    taken_o =  ccr_i[FLAG_Z];
      4'h4:    taken_o = ~ccr_i[FLAG_Z];
      4'h5:    taken_o =  ccr_i[FLAG_V];
      4'h6:    taken_o = ~ccr_i[FLAG_V];
      4'h7:    taken_o =  ccr_i[FLAG_C];
      4'h8:    taken_o = ~ccr_i[FLAG_C];
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore FSM sequencing fetch/decode/execute for the 8-bit accumulator CPU.
module control_unit
  import cu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic [2:0] ALU_Sel,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic       CCR_Load,
  output logic       write
);

  state_t state_q, state_d;
  logic   br_taken;

  cu_branch_cond u_branch_cond (
    .cond_i  (IR[3:0]),
    .ccr_i   (CCR_Result),
    .taken_o (br_taken)
  );

  // State register, asynchronously forced to FETCH_0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH_0;
    else       state_q <= state_d;
  end

  // Next-state sequencing; IR and CCR_Result only matter in DECODE_3.
  always_comb begin
    state_d = FETCH_0;
    case (state_q)
      FETCH_0:   state_d = FETCH_1;
      FETCH_1:   state_d = FETCH_2;
      FETCH_2:   state_d = DECODE_3;
      DECODE_3: begin
        case (IR)
          LDA_IMM: state_d = LDA_IMM_4;
          LDA_DIR: state_d = LDA_DIR_4;
          LDB_IMM: state_d = LDB_IMM_4;
          LDB_DIR: state_d = LDB_DIR_4;
          STA_DIR: state_d = STA_DIR_4;
          STB_DIR: state_d = STB_DIR_4;
          ADD_AB:  state_d = ADD_AB_4;
          SUB_AB:  state_d = SUB_AB_4;
          AND_AB:  state_d = AND_AB_4;
          OR_AB:   state_d = OR_AB_4;
          INCA:    state_d = INCA_4;
          INCB:    state_d = INCB_4;
          DECA:    state_d = DECA_4;
          DECB:    state_d = DECB_4;
          default: begin
            if (is_branch(IR)) state_d = br_taken ? BR_4 : BR_SKIP;
            else               state_d = FETCH_0;
          end
        endcase
      end
      LDA_IMM_4: state_d = LDA_IMM_5;
      LDA_IMM_5: state_d = LDA_IMM_6;
      LDA_DIR_4: state_d = LDA_DIR_5;
      LDA_DIR_5: state_d = LDA_DIR_6;
      LDA_DIR_6: state_d = LDA_DIR_7;
      LDA_DIR_7: state_d = LDA_DIR_8;
      LDB_IMM_4: state_d = LDB_IMM_5;
      LDB_IMM_5: state_d = LDB_IMM_6;
      LDB_DIR_4: state_d = LDB_DIR_5;
      LDB_DIR_5: state_d = LDB_DIR_6;
      LDB_DIR_6: state_d = LDB_DIR_7;
      LDB_DIR_7: state_d = LDB_DIR_8;
      STA_DIR_4: state_d = STA_DIR_5;
      STA_DIR_5: state_d = STA_DIR_6;
      STA_DIR_6: state_d = STA_DIR_7;
      STB_DIR_4: state_d = STB_DIR_5;
      STB_DIR_5: state_d = STB_DIR_6;
      STB_DIR_6: state_d = STB_DIR_7;
      BR_4:      state_d = BR_5;
      BR_5:      state_d = BR_6;
      default:   state_d = FETCH_0;
    endcase
  end

  // Control outputs decoded from state; reset overrides everything so the
  // strobes drop asynchronously even though state is already FETCH_0.
  always_comb begin
    ALU_Sel  = ALU_ADD;
    Bus1_Sel = BUS1_PC;
    Bus2_Sel = BUS2_ALU;
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    A_Load   = 1'b0;
    B_Load   = 1'b0;
    CCR_Load = 1'b0;
    write    = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH_0, LDA_IMM_4, LDA_DIR_4, LDB_IMM_4, LDB_DIR_4,
        STA_DIR_4, STB_DIR_4, BR_4: begin
          Bus1_Sel = BUS1_PC;
          Bus2_Sel = BUS2_BUS1;
          MAR_Load = 1'b1;
        end
        FETCH_1, LDA_IMM_5, LDA_DIR_5, LDB_IMM_5, LDB_DIR_5,
        STA_DIR_5, STB_DIR_5, BR_SKIP: begin
          PC_Inc = 1'b1;
        end
        FETCH_2: begin
          Bus2_Sel = BUS2_MEM;
          IR_Load  = 1'b1;
        end
        LDA_IMM_6, LDA_DIR_8: begin
          Bus2_Sel = BUS2_MEM;
          A_Load   = 1'b1;
        end
        LDB_IMM_6, LDB_DIR_8: begin
          Bus2_Sel = BUS2_MEM;
          B_Load   = 1'b1;
        end
        LDA_DIR_6, LDB_DIR_6, STA_DIR_6, STB_DIR_6: begin
          Bus2_Sel = BUS2_MEM;
          MAR_Load = 1'b1;
        end
        STA_DIR_7: begin
          Bus1_Sel = BUS1_A;
          write    = 1'b1;
        end
        STB_DIR_7: begin
          Bus1_Sel = BUS1_B;
          write    = 1'b1;
        end
        ADD_AB_4, SUB_AB_4, AND_AB_4, OR_AB_4: begin
          Bus1_Sel = BUS1_B;
          Bus2_Sel = BUS2_ALU;
          A_Load   = 1'b1;
          CCR_Load = 1'b1;
          case (state_q)
            SUB_AB_4: ALU_Sel = ALU_SUB;
            AND_AB_4: ALU_Sel = ALU_AND;
            OR_AB_4:  ALU_Sel = ALU_OR;
            default:  ALU_Sel = ALU_ADD;
          endcase
        end
        INCA_4, DECA_4: begin
          Bus1_Sel = BUS1_A;
          Bus2_Sel = BUS2_ALU;
          ALU_Sel  = (state_q == INCA_4) ? ALU_INC : ALU_DEC;
          A_Load   = 1'b1;
          CCR_Load = 1'b1;
        end
        INCB_4, DECB_4: begin
          Bus1_Sel = BUS1_B;
          Bus2_Sel = BUS2_ALU;
          ALU_Sel  = (state_q == INCB_4) ? ALU_INC : ALU_DEC;
          B_Load   = 1'b1;
          CCR_Load = 1'b1;
        end
        BR_6: begin
          Bus2_Sel = BUS2_MEM;
          PC_Load  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected output
// sequences are built from the instruction-set table, then compared cycle by cycle.
module tb_control_unit;

  typedef struct packed {
    logic [2:0] alu;
    logic [1:0] b1;
    logic [1:0] b2;
    logic       ir_ld;
    logic       mar_ld;
    logic       pc_ld;
    logic       pc_inc;
    logic       a_ld;
    logic       b_ld;
    logic       ccr_ld;
    logic       wr;
  } ov_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write;

  ov_t obs;
  ov_t exp_q[$];
  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [7:0] valid_ops[23] = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97,
                                8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49,
                                8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};

  control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .IR         (IR),
    .CCR_Result (CCR_Result),
    .ALU_Sel    (ALU_Sel),
    .Bus1_Sel   (Bus1_Sel),
    .Bus2_Sel   (Bus2_Sel),
    .IR_Load    (IR_Load),
    .MAR_Load   (MAR_Load),
    .PC_Load    (PC_Load),
    .PC_Inc     (PC_Inc),
    .A_Load     (A_Load),
    .B_Load     (B_Load),
    .CCR_Load   (CCR_Load),
    .write      (write)
  );

  always #5 clk = ~clk;

  assign obs = {ALU_Sel, Bus1_Sel, Bus2_Sel, IR_Load, MAR_Load, PC_Load, PC_Inc,
                A_Load, B_Load, CCR_Load, write};

  task automatic check(input string tag, input ov_t e);
    total++;
    assert (obs === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, e);
  endtask

  function automatic logic is_valid(input logic [7:0] op);
    foreach (valid_ops[i]) if (valid_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: the micro-operation sequence an instruction produces,
  // written directly from the instruction-set table.
  function automatic void build(input logic [7:0] op, input logic [3:0] ccr);
    ov_t mar_pc, inc, v;
    logic n, z, ov, c, taken;
    int unsigned k;
    mar_pc = '0; mar_pc.b2 = 2'b01; mar_pc.mar_ld = 1'b1;
    inc    = '0; inc.pc_inc = 1'b1;
    {n, z, ov, c} = ccr;
    exp_q.delete();
    exp_q.push_back(mar_pc);
    exp_q.push_back(inc);
    v = '0; v.b2 = 2'b10; v.ir_ld = 1'b1; exp_q.push_back(v);
    exp_q.push_back('0);
    if (op == 8'h86 || op == 8'h88) begin
      exp_q.push_back(mar_pc);
      exp_q.push_back(inc);
      v = '0; v.b2 = 2'b10; v.a_ld = (op == 8'h86); v.b_ld = (op == 8'h88);
      exp_q.push_back(v);
    end else if (op == 8'h87 || op == 8'h89) begin
      exp_q.push_back(mar_pc);
      exp_q.push_back(inc);
      v = '0; v.b2 = 2'b10; v.mar_ld = 1'b1; exp_q.push_back(v);
      exp_q.push_back('0);
      v = '0; v.b2 = 2'b10; v.a_ld = (op == 8'h87); v.b_ld = (op == 8'h89);
      exp_q.push_back(v);
    end else if (op == 8'h96 || op == 8'h97) begin
      exp_q.push_back(mar_pc);
      exp_q.push_back(inc);
      v = '0; v.b2 = 2'b10; v.mar_ld = 1'b1; exp_q.push_back(v);
      v = '0; v.b1 = (op == 8'h96) ? 2'b01 : 2'b10; v.wr = 1'b1; exp_q.push_back(v);
    end else if (op >= 8'h42 && op <= 8'h49) begin
      k = 32'(op - 8'h42);
      v = '0; v.b2 = 2'b00; v.ccr_ld = 1'b1;
      case (k)
        0, 1, 2, 3: begin v.alu = 3'(k); v.b1 = 2'b10; v.a_ld = 1'b1; end
        4:          begin v.alu = 3'd4;  v.b1 = 2'b01; v.a_ld = 1'b1; end
        5:          begin v.alu = 3'd4;  v.b1 = 2'b10; v.b_ld = 1'b1; end
        6:          begin v.alu = 3'd5;  v.b1 = 2'b01; v.a_ld = 1'b1; end
        default:    begin v.alu = 3'd5;  v.b1 = 2'b10; v.b_ld = 1'b1; end
      endcase
      exp_q.push_back(v);
    end else if (op >= 8'h20 && op <= 8'h28) begin
      case (op)
        8'h20:   taken = 1'b1;
        8'h21:   taken = n;
        8'h22:   taken = !n;
        8'h23:   taken = z;
        8'h24:   taken = !z;
        8'h25:   taken = ov;
        8'h26:   taken = !ov;
        8'h27:   taken = c;
        default: taken = !c;
      endcase
      if (taken) begin
        exp_q.push_back(mar_pc);
        exp_q.push_back('0);
        v = '0; v.b2 = 2'b10; v.pc_ld = 1'b1; exp_q.push_back(v);
      end else begin
        exp_q.push_back(inc);
      end
    end
  endfunction

  // Called at negedge+1 with the DUT in FETCH_0; returns likewise, unless
  // abort_at stops it mid-instruction (without advancing the clock).
  task automatic run_instr(input logic [7:0] op, input logic [3:0] ccr,
                           input bit scramble, input int abort_at);
    IR = op;
    CCR_Result = ccr;
    build(op, ccr);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (scramble && i >= 4) begin
        IR = 8'($urandom);
        CCR_Result = 4'($urandom);
      end
      check($sformatf("op%02h_ccr%04b_cyc%0d", op, ccr, i), exp_q[i]);
      if (i == abort_at) return;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    logic [7:0] op;
    reset = 1'b1;
    IR = 8'h00;
    CCR_Result = 4'h0;
    repeat (2) @(negedge clk);
    #1 check("reset_held", '0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    run_instr(8'h86, 4'b0000, 1'b0, -1);
    run_instr(8'h96, 4'b0000, 1'b0, -1);
    run_instr(8'h24, 4'b0000, 1'b0, -1);
    run_instr(8'h24, 4'b0100, 1'b0, -1);
    run_instr(8'h42, 4'b0000, 1'b0, -1);
    run_instr(8'h48, 4'b0000, 1'b0, -1);
    run_instr(8'hFF, 4'b0000, 1'b0, -1);

    // Abort a store in its write cycle.
    run_instr(8'h96, 4'b0000, 1'b0, 7);
    reset = 1'b1;
    #1 check("reset_async_drop", '0);
    @(posedge clk); #1 check("reset_across_edge", '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    run_instr(8'h87, 4'b0000, 1'b0, -1);
    run_instr(8'h89, 4'b1111, 1'b0, -1);
    run_instr(8'h97, 4'b1111, 1'b0, -1);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        op = valid_ops[$urandom_range(0, 22)];
      end else begin
        op = 8'($urandom);
        while (is_valid(op)) op = 8'($urandom);
      end
      run_instr(op, 4'($urandom), 1'b1, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
